regs_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (regD_addr/regD_data/reg_write_en) between NUM_REQ writeback

---
 rtl/regs_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/regs_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regs_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// ---------------------------------------------------------------------------
// regs_pkg
//   Shared constants for the 16 x 64 register file and every block that talks
//   to its write port (writeback arbiter, issue scoreboard, register file).
//   No ports; this file only holds localparams.
// ---------------------------------------------------------------------------
package regs_pkg;

  // Register file geometry
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 64;
  localparam int REG_NUM    = 16;

  // Architecturally special registers
  localparam int REG_ZERO   = 0;   // hard-wired zero, writes are dropped
  localparam int REG_LR     = 14;  // link register (target of the link writer)
  localparam int REG_SP     = 15;  // stack pointer

endpackage : regs_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at the requester just
//   after ptr (wrapping modulo N) and the first asserted req wins.
//
//   Ports
//     req         in   N    request vector
//     ptr         in   PW   index of the last winner (lowest priority now)
//     enable      in   1    when 0 no grant is issued
//     grant       out  N    one-hot grant, zero when disabled or idle
//     grant_idx   out  PW   binary index of the winner (valid with grant_valid)
//     grant_valid out  1    a grant is being issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  // N expressed in the candidate width so the wrap compare has matching widths.
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [PW:0] cand;
  logic        found;

  // Walk the requesters in priority order ptr+1, ptr+2, ... ptr+N. Since
  // ptr < N and k <= N the sum stays below 2N, so one subtraction wraps it.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found && req[cand[PW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  assign grant_valid = found & enable;
  assign grant       = grant_valid ? (N'(1) << grant_idx) : '0;

endmodule : rr_arbiter

// File: rtl/regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wb_arbiter
//   Shares the single register-file write port between NUM_REQ writeback
//   producers with round-robin arbitration behind a one-entry output register,
//   and keeps a per-register busy scoreboard for RAW hazard detection on the
//   three read ports. Writes commit under the same clock_enable/mmu_ready rule
//   as the register file itself.
//
//   Ports
//     clock         in   1                single clock, posedge
//     reset_in      in   1                sync active-high, honoured only when clock_enable=1
//     clock_enable  in   1                global advance, no state change when 0
//     mmu_ready     in   1                register-file write commits only when 1
//     req_valid     in   NUM_REQ          write pending per requester
//     req_addr      in   NUM_REQ*ADDR_W   packed destination addresses
//     req_data      in   NUM_REQ*DATA_W   packed write data
//     req_ready     out  NUM_REQ          one-hot accept (combinational)
//     regD_addr     out  ADDR_W           registered write address
//     regD_data     out  DATA_W           registered write data
//     reg_write_en  out  1                registered write valid
//     rsv_valid     in   1                issue reserves rsv_addr
//     rsv_addr      in   ADDR_W           register being reserved
//     chk_addr      in   3*ADDR_W         packed read addresses to hazard-check
//     chk_busy      out  3                busy bit of each checked register
//     sb_error      out  1                sticky scoreboard protocol error
// ---------------------------------------------------------------------------
module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset_in,
  input  logic                      clock_enable,
  input  logic                      mmu_ready,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         regD_addr,
  output logic [DATA_W-1:0]         regD_data,
  output logic                      reg_write_en,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic [3*ADDR_W-1:0]       chk_addr,
  output logic [2:0]                chk_busy,
  output logic                      sb_error
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [PW-1:0]     PTR_RESET = PW'(NUM_REQ - 1);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant_idx;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant;
  logic               load_en;
  logic               commit;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_next;
  logic               rsv_set;
  logic               rsv_err;
  logic               commit_err;

  // A commit happens exactly when the register file writes. The output
  // register may be reloaded when it is empty or being drained this edge;
  // a reset edge never loads, so a request presented then is not consumed.
  assign commit  = clock_enable & reg_write_en & mmu_ready;
  assign load_en = clock_enable & ~reset_in & (~reg_write_en | mmu_ready);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .enable      (load_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  // Select the winner's address/data slice.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register and round-robin pointer. A write aimed at r0 is consumed
  // (and moves the pointer) but never raises reg_write_en, so it neither
  // commits nor touches the scoreboard.
  always_ff @(posedge clock) begin
    if (clock_enable) begin
      if (reset_in) begin
        reg_write_en <= 1'b0;
        regD_addr    <= '0;
        regD_data    <= '0;
        rr_ptr       <= PTR_RESET;
      end else if (grant_valid) begin
        reg_write_en <= (win_addr != ZERO_ADDR);
        regD_addr    <= win_addr;
        regD_data    <= win_data;
        rr_ptr       <= grant_idx;
      end else if (commit) begin
        reg_write_en <= 1'b0;
      end
    end
  end

  assign rsv_set = clock_enable & rsv_valid & (rsv_addr != ZERO_ADDR);

  // Scoreboard next state. A reserve and a commit to the same register in one
  // edge means a new producer replaces the one finishing, so the set wins and
  // it is not a double reservation. Bit 0 is forced clear so r0 never looks busy.
  always_comb begin
    busy_next  = busy;
    rsv_err    = 1'b0;
    commit_err = 1'b0;
    if (commit) begin
      commit_err          = ~busy[regD_addr];
      busy_next[regD_addr] = 1'b0;
    end
    if (rsv_set) begin
      rsv_err             = busy[rsv_addr] & ~(commit && (regD_addr == rsv_addr));
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state and the sticky error flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (clock_enable) begin
      if (reset_in) begin
        busy     <= '0;
        sb_error <= 1'b0;
      end else begin
        busy <= busy_next;
        if (rsv_err || commit_err) begin
          sb_error <= 1'b1;
        end
      end
    end
  end

  // Hazard lookups read the registered busy bits only; a commit in this
  // cycle is not bypassed.
  always_comb begin
    chk_busy = '0;
    for (int j = 0; j < 3; j++) begin
      chk_busy[j] = busy[chk_addr[j*ADDR_W +: ADDR_W]];
    end
  end

endmodule : regs_wb_arbiter

// File: tb/tb_regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regs_wb_arbiter
//   Directed tests for the writeback arbiter: reset, round-robin order,
//   mmu stall, scoreboard set/clear, r0 writes, sticky error, clock_enable
//   gating and reset during a stall.
// ---------------------------------------------------------------------------
module tb_regs_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 4;

  logic                      clock;
  logic                      reset_in;
  logic                      clock_enable;
  logic                      mmu_ready;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         regD_addr;
  logic [DATA_W-1:0]         regD_data;
  logic                      reg_write_en;
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic [3*ADDR_W-1:0]       chk_addr;
  logic [2:0]                chk_busy;
  logic                      sb_error;

  int total;
  int bad;

  regs_wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clock        (clock),
    .reset_in     (reset_in),
    .clock_enable (clock_enable),
    .mmu_ready    (mmu_ready),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .regD_addr    (regD_addr),
    .regD_data    (regD_data),
    .reg_write_en (reg_write_en),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .chk_addr     (chk_addr),
    .chk_busy     (chk_busy),
    .sb_error     (sb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    clock_enable = 1'b1;
    mmu_ready    = 1'b1;
    req_valid    = '0;
    rsv_valid    = 1'b0;
    rsv_addr     = '0;
    chk_addr     = '0;
    reset_in     = 1'b1;
    tick();
    reset_in     = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    req_addr = '0;
    req_data = '0;
    do_reset();
    chk_addr = {4'd7, 4'd5, 4'd3};
    settle();
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen got=%b want=0", reg_write_en); end
    total++; if (regD_addr !== 4'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=0", regD_addr); end
    total++; if (regD_data !== 64'd0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", regD_data); end
    total++; if (chk_busy !== 3'b000) begin bad++; $display("[TB] FAIL reset_chk got=%b want=000", chk_busy); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_sberr got=%b want=0", sb_error); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL reset_ready got=%b want=000", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [2:0]        exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    do_reset();
    set_slot(0, 4'd1, 64'hAAAA_0000_0000_0001);
    set_slot(1, 4'd2, 64'hBBBB_0000_0000_0002);
    set_slot(2, 4'd3, 64'hCCCC_0000_0000_0003);
    req_valid = 3'b111;
    settle();
    for (int i = 0; i < 4; i++) begin
      case (i % 3)
        0:       begin exp_ready = 3'b001; exp_addr = 4'd1; exp_data = 64'hAAAA_0000_0000_0001; end
        1:       begin exp_ready = 3'b010; exp_addr = 4'd2; exp_data = 64'hBBBB_0000_0000_0002; end
        default: begin exp_ready = 3'b100; exp_addr = 4'd3; exp_data = 64'hCCCC_0000_0000_0003; end
      endcase
      total++; if (req_ready !== exp_ready) begin bad++; $display("[TB] FAIL rr_ready[%0d] got=%b want=%b", i, req_ready, exp_ready); end
      tick();
      total++; if (reg_write_en !== 1'b1) begin bad++; $display("[TB] FAIL rr_wen[%0d] got=%b want=1", i, reg_write_en); end
      total++; if (regD_addr !== exp_addr) begin bad++; $display("[TB] FAIL rr_addr[%0d] got=%0d want=%0d", i, regD_addr, exp_addr); end
      total++; if (regD_data !== exp_data) begin bad++; $display("[TB] FAIL rr_data[%0d] got=%h want=%h", i, regD_data, exp_data); end
      settle();
    end
    req_valid = '0;
    tick();
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("[TB] FAIL rr_drain got=%b want=0", reg_write_en); end
    // r1..r3 were never reserved, so their commits flag an error
    total++; if (sb_error !== 1'b1) begin bad++; $display("[TB] FAIL rr_commit_unbusy got=%b want=1", sb_error); end
  endtask

  task automatic test_stall();
    do_reset();
    chk_addr = {4'd0, 4'd0, 4'd5};
    rsv_valid = 1'b1; rsv_addr = 4'd5;
    tick();
    rsv_valid = 1'b0;
    set_slot(1, 4'd5, 64'h5555_1234_5678_9ABC);
    req_valid = 3'b010;
    settle();
    total++; if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL stall_first_ready got=%b want=010", req_ready); end
    tick();
    mmu_ready = 1'b0;
    set_slot(0, 4'd6, 64'h6666_0000_0000_0006);
    req_valid = 3'b001;
    settle();
    for (int c = 0; c < 3; c++) begin
      total++; if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL stall_ready[%0d] got=%b want=000", c, req_ready); end
      total++; if (reg_write_en !== 1'b1 || regD_addr !== 4'd5 || regD_data !== 64'h5555_1234_5678_9ABC) begin
        bad++; $display("[TB] FAIL stall_hold[%0d] got=%b/%0d/%h want=1/5/5555123456789abc", c, reg_write_en, regD_addr, regD_data);
      end
      total++; if (chk_busy !== 3'b001) begin bad++; $display("[TB] FAIL stall_busy[%0d] got=%b want=001", c, chk_busy); end
      tick();
    end
    mmu_ready = 1'b1;
    settle();
    total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL stall_release_ready got=%b want=001", req_ready); end
    tick();
    req_valid = '0;
    settle();
    total++; if (reg_write_en !== 1'b1 || regD_addr !== 4'd6) begin bad++; $display("[TB] FAIL stall_next got=%b/%0d want=1/6", reg_write_en, regD_addr); end
    total++; if (chk_busy !== 3'b000) begin bad++; $display("[TB] FAIL stall_commit_clear got=%b want=000", chk_busy); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("[TB] FAIL stall_sberr got=%b want=0", sb_error); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    chk_addr = {4'd0, 4'd0, 4'd7};
    rsv_valid = 1'b1; rsv_addr = 4'd7;
    settle();
    total++; if (chk_busy !== 3'b000) begin bad++; $display("[TB] FAIL sb_no_bypass_set got=%b want=000", chk_busy); end
    tick();
    rsv_valid = 1'b0;
    settle();
    total++; if (chk_busy !== 3'b001) begin bad++; $display("[TB] FAIL sb_reserved got=%b want=001", chk_busy); end
    set_slot(0, 4'd7, 64'h7777_7777_7777_7777);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    settle();
    total++; if (reg_write_en !== 1'b1 || chk_busy !== 3'b001) begin bad++; $display("[TB] FAIL sb_pending got=%b/%b want=1/001", reg_write_en, chk_busy); end
    tick();
    total++; if (chk_busy !== 3'b000 || reg_write_en !== 1'b0) begin bad++; $display("[TB] FAIL sb_commit_clear got=%b/%b want=000/0", chk_busy, reg_write_en); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("[TB] FAIL sb_clean got=%b want=0", sb_error); end
    rsv_valid = 1'b1; rsv_addr = 4'd7;
    tick();
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 4'd7;
    tick();
    rsv_valid = 1'b0;
    settle();
    total++; if (chk_busy !== 3'b001 || reg_write_en !== 1'b0) begin bad++; $display("[TB] FAIL sb_set_wins got=%b/%b want=001/0", chk_busy, reg_write_en); end
    chk_addr = {4'd7, 4'd0, 4'd7};
    settle();
    total++; if (chk_busy !== 3'b101) begin bad++; $display("[TB] FAIL sb_slots got=%b want=101", chk_busy); end
  endtask

  task automatic test_r0_and_errors();
    do_reset();
    set_slot(1, 4'd0, 64'hDEAD_BEEF_0000_0000);
    req_valid = 3'b010;
    settle();
    total++; if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL r0_ready got=%b want=010", req_ready); end
    tick();
    req_valid = '0;
    settle();
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("[TB] FAIL r0_wen got=%b want=0", reg_write_en); end
    req_valid = 3'b111;
    settle();
    total++; if (req_ready !== 3'b100) begin bad++; $display("[TB] FAIL r0_ptr_moved got=%b want=100", req_ready); end
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 4'd3;
    tick();
    total++; if (sb_error !== 1'b0) begin bad++; $display("[TB] FAIL err_first_rsv got=%b want=0", sb_error); end
    tick();
    rsv_valid = 1'b0;
    total++; if (sb_error !== 1'b1) begin bad++; $display("[TB] FAIL err_double_rsv got=%b want=1", sb_error); end
    tick();
    tick();
    total++; if (sb_error !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%b want=1", sb_error); end
  endtask

  task automatic test_clock_enable();
    do_reset();
    set_slot(0, 4'd9, 64'h9999_0000_0000_0009);
    req_valid = 3'b001;
    rsv_valid = 1'b1; rsv_addr = 4'd4;
    chk_addr = {4'd0, 4'd0, 4'd4};
    clock_enable = 1'b0;
    settle();
    total++; if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL ce_ready got=%b want=000", req_ready); end
    tick();
    tick();
    total++; if (reg_write_en !== 1'b0 || chk_busy !== 3'b000) begin bad++; $display("[TB] FAIL ce_frozen got=%b/%b want=0/000", reg_write_en, chk_busy); end
    clock_enable = 1'b1;
    settle();
    total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL ce_resume_ready got=%b want=001", req_ready); end
    tick();
    req_valid = '0;
    rsv_valid = 1'b0;
    settle();
    total++; if (reg_write_en !== 1'b1 || regD_addr !== 4'd9 || chk_busy !== 3'b001) begin
      bad++; $display("[TB] FAIL ce_resume got=%b/%0d/%b want=1/9/001", reg_write_en, regD_addr, chk_busy);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    chk_addr = {4'd0, 4'd0, 4'd5};
    rsv_valid = 1'b1; rsv_addr = 4'd5;
    tick();
    rsv_valid = 1'b0;
    set_slot(1, 4'd5, 64'h0505_0505_0505_0505);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    mmu_ready = 1'b0;
    tick();
    total++; if (reg_write_en !== 1'b1) begin bad++; $display("[TB] FAIL rst_stall_pending got=%b want=1", reg_write_en); end
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    mmu_ready = 1'b1;
    settle();
    total++; if (reg_write_en !== 1'b0 || regD_addr !== 4'd0) begin bad++; $display("[TB] FAIL rst_stall_drop got=%b/%0d want=0/0", reg_write_en, regD_addr); end
    total++; if (chk_busy !== 3'b000) begin bad++; $display("[TB] FAIL rst_stall_busy got=%b want=000", chk_busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_in = 1'b0; clock_enable = 1'b0; mmu_ready = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; chk_addr = '0;
    test_reset();
    test_round_robin();
    test_stall();
    test_scoreboard();
    test_r0_and_errors();
    test_clock_enable();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regs_wb_arbiter
